sd_sector_buf: RTL
==================

# sd_sector_buf

Sector staging buffer that sits directly upstream of the SD single-block writer. It collects a byte stream from the UART receive FIFO into a 512-byte sector memory, then asserts the write request with the current block address. It serves the sector bytes to the writer on demand, waits for the writer's completion flag, and then advances the block address for the next sector.

## Interface
Parameters:
- SECTOR_BYTES, 512, bytes per sector; must be a power of two.
- TIMEOUT, 24'd4000000, number of SD_CK cycles allowed from the write_seq pulse to the rising edge of ok.
- LBA_START, 32'd0, block address used after reset.

Ports:
- SD_CK  in  1  clock; all logic is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- init_o  in  1  card initialisation is complete (level).
- din  in  8  byte from the UART FIFO.
- din_valid  in  1  din holds a valid byte.
- din_ready  out  1  the buffer accepts din this cycle.
- write_seq  out  1  one-cycle start pulse to the writer.
- lba  out  32  block address of the sector being written.
- rd_en  in  1  byte fetch strobe from the writer.
- rd_data  out  8  fetched byte, registered.
- ok  in  1  writer completion flag (level, sticky).
- busy  out  1  high in every state except FILL.
- err  out  1  sticky timeout flag.
- sector_cnt  out  16  number of sectors completed; wraps at 0xFFFF to 0.
- flush  in  1  pad and send a partial sector (present only with SD_BUF_FLUSH_EN).

## Operation
States: FILL, ARM, SEND.
- **Reset values:** state=FILL, din_ready=1, write_seq=0, lba=LBA_START, rd_data=8'hFF, busy=0, err=0, sector_cnt=0, wr_ptr=0, rd_ptr=0, tmo=0, ok_d=0.
- **FILL:** din_ready=1.
  - When din_valid&&din_ready: mem[wr_ptr]<=din and wr_ptr increments.
  - Accepting the byte at wr_ptr==SECTOR_BYTES-1 moves the state to ARM on the next edge; wr_ptr wraps to 0.
- **ARM:** din_ready=0.
  - If init_o=0, stay in ARM.
  - If init_o=1: drive write_seq=1 for exactly one cycle, set rd_ptr=0 and tmo=TIMEOUT, then go to SEND.
- **SEND:**
  - Each rd_en cycle: rd_data<=mem[rd_ptr] and rd_ptr increments.
  - Once rd_ptr==SECTOR_BYTES, rd_ptr saturates and rd_data<=8'hFF.
  - tmo decrements by 1 each cycle.
- **Completion (SEND):**
  - ok rising edge (ok&&!ok_d): lba<=lba+1, sector_cnt<=sector_cnt+1, rd_ptr<=0, state<=FILL.
- **Timeout (SEND):**
  - tmo reaches 0 with no ok rising edge: err<=1 and state<=ARM.
  - The sector is retried with the same lba and the same data.
- **Simultaneous events:**
  - ok rising edge and tmo==0 in the same cycle: completion wins and err is not set.
  - din_valid outside FILL: ignored, no write to mem.
- **Reset mid-operation:** returns every register to its reset value on the next edge; a partially filled or partially sent sector is discarded.
- **Arithmetic:**
  - lba wraps modulo 2^32.
  - The ok edge detector uses a one-flop delay, ok_d, registered every cycle.

## Timing
- din to mem write: same edge. din_ready is combinational from state.
- Last byte accepted to write_seq high: 1 cycle, provided init_o=1.
- rd_en to rd_data valid: 1 cycle (registered read).
- Back-to-back rd_en yields one byte per cycle.
- ok rising edge to din_ready=1: 1 cycle.
- write_seq is never high for two consecutive cycles. The minimum gap between pulses is 2 cycles (SEND→ARM→pulse).

## Configuration
Macro: SD_BUF_FLUSH_EN.
- **Defined:**
  - The flush port exists.
  - flush=1 in FILL with wr_ptr!=0 enters a PAD sub-phase: din_ready=0, and 8'hFF is written to mem[wr_ptr] each cycle until wr_ptr wraps, then the state goes to ARM.
  - flush with wr_ptr==0 is ignored.
  - flush outside FILL is ignored.
- **Undefined:**
  - No flush port and no PAD logic.
  - Only a full sector triggers ARM.

## Test plan
- **Full sector:** reset, init_o=1, stream bytes 0..255,0..255 → write_seq pulses once with lba=0. Reading 512 rd_en returns the same sequence. ok rising → lba=1, sector_cnt=1, din_ready=1.
- **Gated on init:** init_o=0 while a full sector is buffered → no write_seq and busy=1. Raising init_o → write_seq on the next edge.
- **Over-read:** 520 rd_en strobes → bytes 513..520 read 8'hFF and rd_ptr holds at 512.
- **Timeout:** TIMEOUT=100 with ok held 0 → err=1 at cycle 100 after write_seq, followed by a second write_seq with lba unchanged. Re-read returns the original data.
- **Simultaneous:** ok rising edge in the same cycle as tmo==0 → err stays 0 and lba increments.
- **Flush (SD_BUF_FLUSH_EN):** 10 bytes then flush → bytes 10..511 read 8'hFF and write_seq fires after the pad completes.

Source files
------------

// File: rtl/sd_sector_buf.sv
// Stages one sector from the UART byte stream, launches the SD writer and serves bytes back (rd_data 1 cycle after rd_en).
// din_ready is low outside FILL; with SD_BUF_FLUSH_EN a flush input pads a partial sector with 8'hFF.
module sd_sector_buf #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter logic [23:0] TIMEOUT      = 24'd4000000,
  parameter logic [31:0] LBA_START    = 32'd0
) (
  input  logic        SD_CK,
  input  logic        rst,
  input  logic        init_o,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        write_seq,
  output logic [31:0] lba,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  input  logic        ok,
  output logic        busy,
  output logic        err,
  output logic [15:0] sector_cnt
`ifdef SD_BUF_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int unsigned      PTR_W    = $clog2(SECTOR_BYTES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SECTOR_BYTES - 1);
  localparam logic [PTR_W:0]   END_IDX  = (PTR_W + 1)'(SECTOR_BYTES);

  typedef enum logic [1:0] {FILL, ARM, SEND} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [23:0]        tmo_q, tmo_d;
  logic [31:0]        lba_q, lba_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               write_seq_q, write_seq_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               ok_d_q, ok_d_d;
  logic               ok_rise;
  logic               mem_we;
  logic [7:0]         mem_wdata;
  logic [7:0]         mem [SECTOR_BYTES];
`ifdef SD_BUF_FLUSH_EN
  logic               pad_q, pad_d;

  assign din_ready = (state_q == FILL) && !pad_q;
`else
  assign din_ready = (state_q == FILL);
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tmo_d       = tmo_q;
    lba_d       = lba_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    write_seq_d = 1'b0;
    rd_data_d   = rd_data_q;
    ok_d_d      = ok;
    ok_rise     = ok && !ok_d_q;
    mem_we      = 1'b0;
    mem_wdata   = din;
`ifdef SD_BUF_FLUSH_EN
    pad_d       = pad_q;
`endif
    unique case (state_q)
      FILL: begin
        mem_we = din_valid && din_ready;
`ifdef SD_BUF_FLUSH_EN
        if (pad_q) begin
          mem_we    = 1'b1;
          mem_wdata = 8'hFF;
        end
`endif
        if (mem_we) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            state_d = ARM;
`ifdef SD_BUF_FLUSH_EN
            pad_d   = 1'b0;
`endif
          end
        end
`ifdef SD_BUF_FLUSH_EN
        // An empty buffer has nothing to pad, so flush only acts on a partial sector.
        if (flush && !pad_q && (wr_ptr_q != '0) && (state_d == FILL)) pad_d = 1'b1;
`endif
      end
      ARM: begin
        if (init_o) begin
          write_seq_d = 1'b1;
          rd_ptr_d    = '0;
          tmo_d       = TIMEOUT;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (rd_en) begin
          if (rd_ptr_q == END_IDX) begin
            rd_data_d = 8'hFF;
          end else begin
            rd_data_d = mem[rd_ptr_q[PTR_W-1:0]];
            rd_ptr_d  = rd_ptr_q + 1'b1;
          end
        end
        if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
        // Completion outranks an expiring timer in the same cycle.
        if (ok_rise) begin
          lba_d    = lba_q + 32'd1;
          cnt_d    = cnt_q + 16'd1;
          rd_ptr_d = '0;
          state_d  = FILL;
        end else if (tmo_q <= 24'd1) begin
          err_d   = 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge SD_CK) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_q       <= '0;
      lba_q       <= LBA_START;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      write_seq_q <= 1'b0;
      rd_data_q   <= 8'hFF;
      ok_d_q      <= 1'b0;
`ifdef SD_BUF_FLUSH_EN
      pad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      lba_q       <= lba_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      write_seq_q <= write_seq_d;
      rd_data_q   <= rd_data_d;
      ok_d_q      <= ok_d_d;
`ifdef SD_BUF_FLUSH_EN
      pad_q       <= pad_d;
`endif
    end
  end

  // Sector storage carries no reset; stale contents are always overwritten before a launch.
  always_ff @(posedge SD_CK) begin
    if (mem_we && !rst) mem[wr_ptr_q] <= mem_wdata;
  end

  assign write_seq  = write_seq_q;
  assign lba        = lba_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q != FILL);
  assign err        = err_q;
  assign sector_cnt = cnt_q;

endmodule
